cpu_control_fsm: RTL and testbench

Multi-cycle sequencer for the single-issue RV32I core. It owns the PC and instruction register and drives instruction fetch through a valid/ready memory port. It presents the latched instruction to the instruction decoder and uses the decoder's opcode-class flags to step the datapath through execute, memory and writeback. It also counts retired instructions and stops the core on invalid opcodes, misaligned targets and ECALL/EBREAK.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/cpu_control_fsm_if.sv | 30 +++
 rtl/cpu_control_fsm_pc_unit.sv | 39 +++
 rtl/cpu_control_fsm.sv | 134 +++++++++++++
 tb/tb_cpu_control_fsm.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    MEM_REQ,
    MEM_WAIT,
    WRITEBACK,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    TRAP_NONE,
    TRAP_ILLEGAL,
    TRAP_MISALIGNED,
    TRAP_ENVIRONMENT
  } trap_cause_t;

  localparam int INSTRUCTION_BYTES = 4;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Instruction and data memory valid/ready ports of the control sequencer.
interface cpu_control_fsm_if #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int INSTRUCTION_WIDTH = 32
);

  logic                         imem_req_valid;
  logic                         imem_req_ready;
  logic [ADDRESS_WIDTH-1:0]     imem_addr;
  logic                         imem_resp_valid;
  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data;

  logic                         dmem_req_valid;
  logic                         dmem_req_write;
  logic                         dmem_req_ready;
  logic                         dmem_resp_valid;

  modport master (
    output imem_req_valid, imem_addr, dmem_req_valid, dmem_req_write,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           dmem_req_ready, dmem_resp_valid
  );

  modport slave (
    input  imem_req_valid, imem_addr, dmem_req_valid, dmem_req_write,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           dmem_req_ready, dmem_resp_valid
  );

endinterface

// File: rtl/cpu_control_fsm_pc_unit.sv
// PC register with next-PC selection and target alignment check.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit,
  input  logic                     immediate_jump,
  input  logic                     register_jump,
  input  logic                     branch,
  input  logic                     branch_taken,
  input  logic [ADDRESS_WIDTH-1:0] jump_target,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     misaligned
);

  logic                     take_target;
  logic [ADDRESS_WIDTH-1:0] next_pc;

  // Sequential increment wraps naturally at the address width.
  always_comb begin
    take_target = immediate_jump || register_jump || (branch && branch_taken);
    next_pc     = take_target ? jump_target
                              : pc + ADDRESS_WIDTH'(INSTRUCTION_BYTES);
    misaligned  = |next_pc[1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (commit) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle sequencer: fetch, decode, execute, memory and writeback for the RV32I core.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH     = 32,
  parameter int                       INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  cpu_control_fsm_if.master            mem,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
  output logic [ADDRESS_WIDTH-1:0]     pc,
  input  logic                         opcode_valid,
  input  logic                         load,
  input  logic                         store,
  input  logic                         branch,
  input  logic                         immediate_jump,
  input  logic                         register_jump,
  input  logic                         environment,
  input  logic                         write_register_valid,
  input  logic                         branch_taken,
  input  logic [ADDRESS_WIDTH-1:0]     jump_target,
  output logic                         alu_enable,
  output logic                         regfile_write_enable,
  output logic [31:0]                  instret,
  output logic                         halted,
  output logic [1:0]                   trap_cause
);

  state_t      state, next_state;
  trap_cause_t trap_q, trap_d;
  logic        commit, latch_instruction, misaligned;
  logic        imem_req_valid, dmem_req_valid, dmem_req_write;

  pc_unit #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .RESET_PC      (RESET_PC)
  ) u_pc_unit (
    .clk            (clk),
    .rst            (rst),
    .commit         (commit),
    .immediate_jump (immediate_jump),
    .register_jump  (register_jump),
    .branch         (branch),
    .branch_taken   (branch_taken),
    .jump_target    (jump_target),
    .pc             (pc),
    .misaligned     (misaligned)
  );

  always_comb begin
    next_state           = state;
    trap_d               = trap_q;
    imem_req_valid       = 1'b0;
    dmem_req_valid       = 1'b0;
    dmem_req_write       = 1'b0;
    alu_enable           = 1'b0;
    regfile_write_enable = 1'b0;
    commit               = 1'b0;
    latch_instruction    = 1'b0;
    case (state)
      // Reset parks the state in FETCH_REQ, so the request is masked while rst is low.
      FETCH_REQ: begin
        imem_req_valid = rst;
        if (mem.imem_req_ready) next_state = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (mem.imem_resp_valid) begin
          latch_instruction = 1'b1;
          next_state        = DECODE;
        end
      end
      DECODE: begin
        if (!opcode_valid) begin
          trap_d     = TRAP_ILLEGAL;
          next_state = HALT;
        end else if (environment) begin
          trap_d     = TRAP_ENVIRONMENT;
          next_state = HALT;
        end else begin
          next_state = EXECUTE;
        end
      end
      EXECUTE: begin
        alu_enable = 1'b1;
        next_state = (load || store) ? MEM_REQ : WRITEBACK;
      end
      MEM_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_req_write = store;
        if (mem.dmem_req_ready) next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem.dmem_resp_valid) next_state = WRITEBACK;
      end
      // A misaligned target retires nothing: no register write, PC and instret stay put.
      WRITEBACK: begin
        if (misaligned) begin
          trap_d     = TRAP_MISALIGNED;
          next_state = HALT;
        end else begin
          regfile_write_enable = write_register_valid;
          commit               = 1'b1;
          next_state           = FETCH_REQ;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= FETCH_REQ;
      trap_q           <= TRAP_NONE;
      instruction_data <= '0;
      instret          <= '0;
    end else begin
      state  <= next_state;
      trap_q <= trap_d;
      if (latch_instruction) instruction_data <= mem.imem_resp_data;
      if (commit)            instret          <= instret + 32'd1;
    end
  end

  assign mem.imem_req_valid = imem_req_valid;
  assign mem.imem_addr      = pc;
  assign mem.dmem_req_valid = dmem_req_valid;
  assign mem.dmem_req_write = dmem_req_write;
  assign halted             = (state == HALT);
  assign trap_cause         = trap_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: bench-side decoder and memory responder, hand-computed expectations.
module tb_cpu_control_fsm;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk;
  logic          rst;
  logic [IW-1:0] instruction_data;
  logic [AW-1:0] pc;
  logic          opcode_valid, load, store, branch;
  logic          immediate_jump, register_jump, environment, write_register_valid;
  logic          branch_taken;
  logic [AW-1:0] jump_target;
  logic          alu_enable, regfile_write_enable, halted;
  logic [31:0]   instret;
  logic [1:0]    trap_cause;

  int vectors;
  int miscompares;

  cpu_control_fsm_if #(.ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) mem_bus ();

  cpu_control_fsm #(
    .ADDRESS_WIDTH     (AW),
    .INSTRUCTION_WIDTH (IW),
    .RESET_PC          (32'h0000_0000)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem                  (mem_bus),
    .instruction_data     (instruction_data),
    .pc                   (pc),
    .opcode_valid         (opcode_valid),
    .load                 (load),
    .store                (store),
    .branch               (branch),
    .immediate_jump       (immediate_jump),
    .register_jump        (register_jump),
    .environment          (environment),
    .write_register_valid (write_register_valid),
    .branch_taken         (branch_taken),
    .jump_target          (jump_target),
    .alu_enable           (alu_enable),
    .regfile_write_enable (regfile_write_enable),
    .instret              (instret),
    .halted               (halted),
    .trap_cause           (trap_cause)
  );

  always #5 clk = ~clk;

  // Minimal RV32I opcode-class decoder standing in for the real one.
  always_comb begin
    opcode_valid         = 1'b0;
    load                 = 1'b0;
    store                = 1'b0;
    branch               = 1'b0;
    immediate_jump       = 1'b0;
    register_jump        = 1'b0;
    environment          = 1'b0;
    write_register_valid = 1'b0;
    case (instruction_data[6:0])
      7'h33, 7'h13, 7'h37, 7'h17: begin opcode_valid = 1'b1; write_register_valid = 1'b1; end
      7'h03: begin opcode_valid = 1'b1; load = 1'b1; write_register_valid = 1'b1; end
      7'h23: begin opcode_valid = 1'b1; store = 1'b1; end
      7'h63: begin opcode_valid = 1'b1; branch = 1'b1; end
      7'h6F: begin opcode_valid = 1'b1; immediate_jump = 1'b1; write_register_valid = 1'b1; end
      7'h67: begin opcode_valid = 1'b1; register_jump = 1'b1; write_register_valid = 1'b1; end
      7'h73: begin opcode_valid = 1'b1; environment = 1'b1; end
      default: ;
    endcase
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one instruction through the core, acting as both memories; stops at the next fetch or at halt.
  task automatic run_instr(input logic [31:0] instr, input int i_ready_delay,
                           input int d_ready_delay, input int d_resp_delay,
                           output int cycles, output logic [31:0] fetch_addr,
                           output int wb_cycle, output int dresp_cycle,
                           output int dvalid_cycles, output logic dwrite_seen,
                           output int alu_pulses, output logic timed_out);
    int   iw, dw, dcount;
    logic imem_pending, done_fetch, finished;
    iw = 0; dw = 0; dcount = 0;
    imem_pending = 1'b0; done_fetch = 1'b0; finished = 1'b0;
    cycles = 0; fetch_addr = '1; wb_cycle = 0; dresp_cycle = 0;
    dvalid_cycles = 0; dwrite_seen = 1'b0; alu_pulses = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      mem_bus.imem_req_ready  = 1'b0;
      mem_bus.imem_resp_valid = 1'b0;
      mem_bus.dmem_req_ready  = 1'b0;
      mem_bus.dmem_resp_valid = 1'b0;
      if ((done_fetch && mem_bus.imem_req_valid) || halted) begin
        cycles   = c - 1;
        finished = 1'b1;
        break;
      end
      if (imem_pending) begin
        mem_bus.imem_resp_valid = 1'b1;
        mem_bus.imem_resp_data  = instr;
        imem_pending            = 1'b0;
      end
      if (mem_bus.imem_req_valid && !done_fetch) begin
        if (iw >= i_ready_delay) begin
          mem_bus.imem_req_ready = 1'b1;
          imem_pending           = 1'b1;
          done_fetch             = 1'b1;
          fetch_addr             = mem_bus.imem_addr;
        end
        iw++;
      end
      if (dcount > 0) begin
        dcount--;
        if (dcount == 0) begin
          mem_bus.dmem_resp_valid = 1'b1;
          dresp_cycle             = c;
        end
      end
      if (mem_bus.dmem_req_valid) begin
        dvalid_cycles++;
        if (mem_bus.dmem_req_write) dwrite_seen = 1'b1;
        if (dw >= d_ready_delay) begin
          mem_bus.dmem_req_ready = 1'b1;
          dcount                 = d_resp_delay;
        end
        dw++;
      end
      if (regfile_write_enable) wb_cycle = c;
      if (alu_enable) alu_pulses++;
    end
    mem_bus.imem_req_ready  = 1'b0;
    mem_bus.imem_resp_valid = 1'b0;
    mem_bus.dmem_req_ready  = 1'b0;
    mem_bus.dmem_resp_valid = 1'b0;
    timed_out = !finished;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    vectors++; if (instret !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret); end
    vectors++; if (instruction_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_ir: got %h expected 0", instruction_data); end
    vectors++; if (halted !== 1'b0 || trap_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_halt: got halted=%b trap=%0d expected 0/0", halted, trap_cause); end
    vectors++; if ({mem_bus.imem_req_valid, mem_bus.dmem_req_valid, alu_enable, regfile_write_enable} !== 4'b0) begin
      miscompares++; $display("[TB] FAIL reset_outputs: got %b expected 0000",
        {mem_bus.imem_req_valid, mem_bus.dmem_req_valid, alu_enable, regfile_write_enable}); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (mem_bus.imem_req_valid !== 1'b1 || mem_bus.imem_addr !== 32'h0) begin
      miscompares++; $display("[TB] FAIL release_fetch: got valid=%b addr=%h expected 1/0", mem_bus.imem_req_valid, mem_bus.imem_addr); end
  endtask

  task automatic test_alu(input logic [31:0] exp_addr, input logic [31:0] exp_instret);
    int cyc, wb, dresp, dvalid, alu; logic [31:0] faddr; logic dwr, to;
    run_instr(32'h0000_0033, 0, 0, 1, cyc, faddr, wb, dresp, dvalid, dwr, alu, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL alu_timeout: got %b expected 0", to); end
    vectors++; if (faddr !== exp_addr) begin miscompares++; $display("[TB] FAIL alu_fetch_addr: got %h expected %h", faddr, exp_addr); end
    vectors++; if (wb !== 5) begin miscompares++; $display("[TB] FAIL alu_wb_cycle: got %0d expected 5", wb); end
    vectors++; if (cyc !== 5) begin miscompares++; $display("[TB] FAIL alu_latency: got %0d expected 5", cyc); end
    vectors++; if (alu !== 1 || dvalid !== 0) begin miscompares++; $display("[TB] FAIL alu_pulses: got alu=%0d dmem=%0d expected 1/0", alu, dvalid); end
    vectors++; if (pc !== exp_addr + 32'h4) begin miscompares++; $display("[TB] FAIL alu_pc: got %h expected %h", pc, exp_addr + 32'h4); end
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("[TB] FAIL alu_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_branch(input logic taken, input logic [31:0] exp_pc, input logic [31:0] exp_instret);
    int cyc, wb, dresp, dvalid, alu; logic [31:0] faddr; logic dwr, to;
    branch_taken = taken;
    jump_target  = 32'h0000_0040;
    run_instr(32'h0000_0463, 0, 0, 1, cyc, faddr, wb, dresp, dvalid, dwr, alu, to);
    branch_taken = 1'b0;
    vectors++; if (to !== 1'b0 || cyc !== 5) begin miscompares++; $display("[TB] FAIL branch_latency: got %0d (timeout %b) expected 5", cyc, to); end
    vectors++; if (pc !== exp_pc) begin miscompares++; $display("[TB] FAIL branch_pc: got %h expected %h", pc, exp_pc); end
    vectors++; if (wb !== 0) begin miscompares++; $display("[TB] FAIL branch_no_write: got write at cycle %0d expected none", wb); end
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("[TB] FAIL branch_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_load();
    int cyc, wb, dresp, dvalid, alu; logic [31:0] faddr; logic dwr, to;
    run_instr(32'h0000_2083, 0, 3, 2, cyc, faddr, wb, dresp, dvalid, dwr, alu, to);
    vectors++; if (to !== 1'b0 || cyc !== 11) begin miscompares++; $display("[TB] FAIL load_latency: got %0d (timeout %b) expected 11", cyc, to); end
    vectors++; if (dvalid !== 4) begin miscompares++; $display("[TB] FAIL load_req_cycles: got %0d expected 4", dvalid); end
    vectors++; if (dwr !== 1'b0) begin miscompares++; $display("[TB] FAIL load_req_write: got %b expected 0", dwr); end
    vectors++; if (dresp !== 10 || wb !== 11) begin miscompares++; $display("[TB] FAIL load_wb_timing: got resp=%0d wb=%0d expected 10/11", dresp, wb); end
    vectors++; if (pc !== 32'h0000_000C || instret !== 32'd3) begin
      miscompares++; $display("[TB] FAIL load_retire: got pc=%h instret=%0d expected 0000000c/3", pc, instret); end
  endtask

  task automatic test_store();
    int cyc, wb, dresp, dvalid, alu; logic [31:0] faddr; logic dwr, to;
    run_instr(32'h0010_2023, 0, 0, 1, cyc, faddr, wb, dresp, dvalid, dwr, alu, to);
    vectors++; if (to !== 1'b0 || cyc !== 7) begin miscompares++; $display("[TB] FAIL store_latency: got %0d (timeout %b) expected 7", cyc, to); end
    vectors++; if (dvalid !== 1 || dwr !== 1'b1) begin miscompares++; $display("[TB] FAIL store_req: got cycles=%0d write=%b expected 1/1", dvalid, dwr); end
    vectors++; if (wb !== 0) begin miscompares++; $display("[TB] FAIL store_no_write: got write at cycle %0d expected none", wb); end
    vectors++; if (pc !== 32'h0000_0010 || instret !== 32'd4) begin
      miscompares++; $display("[TB] FAIL store_retire: got pc=%h instret=%0d expected 00000010/4", pc, instret); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    mem_bus.imem_req_ready = 1'b1;
    @(negedge clk);
    mem_bus.imem_req_ready = 1'b0;
    vectors++; if (mem_bus.imem_req_valid !== 1'b0 || pc !== 32'h40) begin
      miscompares++; $display("[TB] FAIL fetch_wait_entry: got valid=%b pc=%h expected 0/00000040", mem_bus.imem_req_valid, pc); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (pc !== 32'h0 || instret !== 32'd0 || instruction_data !== 32'h0) begin
      miscompares++; $display("[TB] FAIL async_reset_regs: got pc=%h instret=%0d ir=%h expected 0/0/0", pc, instret, instruction_data); end
    vectors++; if (mem_bus.imem_req_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++; $display("[TB] FAIL async_reset_outputs: got valid=%b halted=%b expected 0/0", mem_bus.imem_req_valid, halted); end
    @(negedge clk);
    rst = 1'b1;
    mem_bus.imem_resp_valid = 1'b1;
    mem_bus.imem_resp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_bus.imem_resp_valid = 1'b0;
    vectors++; if (mem_bus.imem_req_valid !== 1'b1 || mem_bus.imem_addr !== 32'h0) begin
      miscompares++; $display("[TB] FAIL restart_fetch: got valid=%b addr=%h expected 1/0", mem_bus.imem_req_valid, mem_bus.imem_addr); end
    vectors++; if (instruction_data !== 32'h0) begin miscompares++; $display("[TB] FAIL stray_resp_ignored: got ir=%h expected 0", instruction_data); end
  endtask

  task automatic test_misaligned();
    int cyc, wb, dresp, dvalid, alu; logic [31:0] faddr; logic dwr, to;
    jump_target = 32'h0000_0042;
    run_instr(32'h0001_00E7, 0, 0, 1, cyc, faddr, wb, dresp, dvalid, dwr, alu, to);
    vectors++; if (to !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("[TB] FAIL misaligned_halt: got halted=%b timeout=%b expected 1/0", halted, to); end
    vectors++; if (trap_cause !== 2'd2) begin miscompares++; $display("[TB] FAIL misaligned_cause: got %0d expected 2", trap_cause); end
    vectors++; if (pc !== 32'h4 || instret !== 32'd1) begin miscompares++; $display("[TB] FAIL misaligned_state: got pc=%h instret=%0d expected 00000004/1", pc, instret); end
    vectors++; if (wb !== 0) begin miscompares++; $display("[TB] FAIL misaligned_no_write: got write at cycle %0d expected none", wb); end
  endtask

  task automatic test_illegal();
    int cyc, wb, dresp, dvalid, alu; logic [31:0] faddr; logic dwr, to;
    apply_reset();
    vectors++; if (halted !== 1'b0 || trap_cause !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_exits_halt: got halted=%b trap=%0d expected 0/0", halted, trap_cause); end
    run_instr(32'h0000_0000, 0, 0, 1, cyc, faddr, wb, dresp, dvalid, dwr, alu, to);
    vectors++; if (to !== 1'b0 || halted !== 1'b1 || trap_cause !== 2'd1) begin
      miscompares++; $display("[TB] FAIL illegal_halt: got halted=%b trap=%0d timeout=%b expected 1/1/0", halted, trap_cause, to); end
    vectors++; if (dvalid !== 0 || alu !== 0) begin miscompares++; $display("[TB] FAIL illegal_no_activity: got dmem=%0d alu=%0d expected 0/0", dvalid, alu); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_bus.imem_req_ready  = 1'b1;
      mem_bus.imem_resp_valid = 1'b1;
      mem_bus.imem_resp_data  = 32'h0000_0033;
    end
    @(negedge clk);
    mem_bus.imem_req_ready  = 1'b0;
    mem_bus.imem_resp_valid = 1'b0;
    vectors++; if (halted !== 1'b1 || instruction_data !== 32'h0 || mem_bus.imem_req_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL halt_sticky: got halted=%b ir=%h valid=%b expected 1/0/0", halted, instruction_data, mem_bus.imem_req_valid); end
    vectors++; if (pc !== 32'h0 || instret !== 32'd0) begin miscompares++; $display("[TB] FAIL illegal_state: got pc=%h instret=%0d expected 0/0", pc, instret); end
  endtask

  task automatic test_environment();
    int cyc, wb, dresp, dvalid, alu; logic [31:0] faddr; logic dwr, to;
    apply_reset();
    run_instr(32'h0000_0073, 0, 0, 1, cyc, faddr, wb, dresp, dvalid, dwr, alu, to);
    vectors++; if (to !== 1'b0 || halted !== 1'b1 || trap_cause !== 2'd3) begin
      miscompares++; $display("[TB] FAIL ecall_halt: got halted=%b trap=%0d timeout=%b expected 1/3/0", halted, trap_cause, to); end
    vectors++; if (alu !== 0 || instret !== 32'd0) begin miscompares++; $display("[TB] FAIL ecall_no_retire: got alu=%0d instret=%0d expected 0/0", alu, instret); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    vectors = 0;
    miscompares = 0;
    branch_taken = 1'b0;
    jump_target = '0;
    mem_bus.imem_req_ready  = 1'b0;
    mem_bus.imem_resp_valid = 1'b0;
    mem_bus.imem_resp_data  = '0;
    mem_bus.dmem_req_ready  = 1'b0;
    mem_bus.dmem_resp_valid = 1'b0;

    test_reset();
    test_alu(32'h0, 32'd1);
    test_branch(1'b0, 32'h0000_0008, 32'd2);
    test_load();
    test_store();
    test_branch(1'b1, 32'h0000_0040, 32'd5);
    test_async_reset();
    test_alu(32'h0, 32'd1);
    test_misaligned();
    test_illegal();
    test_environment();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
